// File: rtl/gaussian_pkg.sv
// Shared constants, FSM state type and window slice helper for the
// Gaussian window generator.
package gaussian_pkg;

  localparam int BITS    = 8;
  localparam int WIDTH   = 7;
  localparam int MASKLEN = BITS * WIDTH * WIDTH;
  localparam int ADDRLEN = 21;
  localparam int LB_ROWS = WIDTH - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_OUT,
    ST_FIN
  } state_t;

  // Bit offset of window pixel (row r, column c); row 0 / column 0 is top-left.
  function automatic int win_idx(input int r, input int c);
    return BITS * (r * WIDTH + c);
  endfunction

endpackage

// File: rtl/gaussian_window_gen_if.sv
// DRAM read port plus window valid/ready stream of the Gaussian window
// generator. Optional coordinate signals exist only with GWIN_COORD_EN.
interface gaussian_window_gen_if;
  import gaussian_pkg::*;

  logic               rd_en;
  logic [ADDRLEN-1:0] rd_addr;
  logic [BITS-1:0]    rd_data;
  logic               win_valid;
  logic               win_ready;
  logic [MASKLEN-1:0] win_data;
`ifdef GWIN_COORD_EN
  logic [ADDRLEN-1:0] win_x;
  logic [ADDRLEN-1:0] win_y;

  modport master (output rd_en, rd_addr, input rd_data,
                  output win_valid, win_data, input win_ready,
                  output win_x, win_y);
  modport slave  (input rd_en, rd_addr, output rd_data,
                  input win_valid, win_data, output win_ready,
                  input win_x, win_y);
`else
  modport master (output rd_en, rd_addr, input rd_data,
                  output win_valid, win_data, input win_ready);
  modport slave  (input rd_en, rd_addr, output rd_data,
                  input win_valid, win_data, output win_ready);
`endif

endinterface

// File: rtl/gwin_line_buffer.sv
// Six-row line store addressed by column. One column word holds the six
// previous rows at that column (row 0 oldest), so a CAP cycle is a single
// read-modify-write of one word. Contents are never cleared: every word is
// written before the window gate lets it reach an output.
module gwin_line_buffer
  import gaussian_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [CW-1:0]           i_col,
  input  logic [LB_ROWS*BITS-1:0] i_wdata,
  output logic [LB_ROWS*BITS-1:0] o_rdata
);

  logic [LB_ROWS*BITS-1:0] r_mem [IMG_W];

  assign o_rdata = r_mem[i_col];

  // Write back the shifted column in the same cycle it is read.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_col] <= i_wdata;
  end

endmodule

// File: rtl/gaussian_window_gen.sv
// Raster-scans an IMG_W x IMG_H image from pixel DRAM, keeps six line
// buffers plus a 7x7 shift window, and emits each fully interior window
// under valid/ready. Optional macro GWIN_COORD_EN adds win_x/win_y
// (window centre coordinates) on the interface.
module gaussian_window_gen
  import gaussian_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  gaussian_window_gen_if.master bus
);

  localparam int                 LP_CW     = $clog2(IMG_W);
  localparam logic [ADDRLEN-1:0] LP_X_LAST = ADDRLEN'(IMG_W - 1);
  localparam logic [ADDRLEN-1:0] LP_Y_LAST = ADDRLEN'(IMG_H - 1);
  localparam logic [ADDRLEN-1:0] LP_EDGE   = ADDRLEN'(WIDTH - 1);
  localparam logic [ADDRLEN-1:0] LP_ONE    = ADDRLEN'(1);
  localparam logic [ADDRLEN-1:0] LP_HALF   = ADDRLEN'(WIDTH / 2);

  state_t               r_state;
  logic [ADDRLEN-1:0]   r_x;
  logic [ADDRLEN-1:0]   r_y;
  logic [ADDRLEN-1:0]   r_pix;
  logic                 r_rd_en;
  logic [ADDRLEN-1:0]   r_rd_addr;
  logic                 r_win_valid;
  logic [MASKLEN-1:0]   r_win_data;
  logic [MASKLEN-1:0]   r_win;
  logic                 r_busy;
  logic                 r_done;
`ifdef GWIN_COORD_EN
  logic [ADDRLEN-1:0]   r_win_x;
  logic [ADDRLEN-1:0]   r_win_y;
`endif

  logic [LB_ROWS*BITS-1:0] w_lb_rd;
  logic [LB_ROWS*BITS-1:0] w_lb_wr;
  logic [WIDTH*BITS-1:0]   w_col;
  logic [MASKLEN-1:0]      w_win_shift;
  logic [ADDRLEN-1:0]      w_x_nxt;
  logic [ADDRLEN-1:0]      w_y_nxt;
  logic                    w_at_window;
  logic                    w_last;

  // Raster advance; the pixel counter r_pix tracks y*IMG_W+x without a multiply.
  assign w_x_nxt     = (r_x == LP_X_LAST) ? '0 : r_x + LP_ONE;
  assign w_y_nxt     = (r_x == LP_X_LAST) ? r_y + LP_ONE : r_y;
  assign w_at_window = (r_x >= LP_EDGE) && (r_y >= LP_EDGE);
  assign w_last      = (r_x == LP_X_LAST) && (r_y == LP_Y_LAST);

  // New column (stored rows on top, fresh pixel at bottom) and the shifted window.
  always_comb begin
    w_col       = {bus.rd_data, w_lb_rd};
    w_lb_wr     = w_col[WIDTH*BITS-1:BITS];
    w_win_shift = '0;
    for (int r = 0; r < WIDTH; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        if (c < WIDTH - 1)
          w_win_shift[win_idx(r, c) +: BITS] = r_win[win_idx(r, c + 1) +: BITS];
        else
          w_win_shift[win_idx(r, c) +: BITS] = w_col[r*BITS +: BITS];
      end
    end
  end

  gwin_line_buffer #(
    .IMG_W (IMG_W),
    .CW    (LP_CW)
  ) u_line_buffer (
    .clk     (clk),
    .i_we    (r_state == ST_CAP),
    .i_col   (r_x[LP_CW-1:0]),
    .i_wdata (w_lb_wr),
    .o_rdata (w_lb_rd)
  );

  // Working window shifts one column per captured pixel; no reset needed.
  always_ff @(posedge clk) begin
    if (r_state == ST_CAP) r_win <= w_win_shift;
  end

  // Scan sequencer with registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_pix       <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef GWIN_COORD_EN
      r_win_x     <= '0;
      r_win_y     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x       <= '0;
            r_y       <= '0;
            r_pix     <= '0;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_RD;
          end
        end
        ST_RD: begin
          r_rd_en <= 1'b0;
          r_state <= ST_CAP;
        end
        ST_CAP: begin
          if (w_at_window) begin
            r_win_data  <= w_win_shift;
            r_win_valid <= 1'b1;
`ifdef GWIN_COORD_EN
            r_win_x     <= r_x - LP_HALF;
            r_win_y     <= r_y - LP_HALF;
`endif
            r_state     <= ST_OUT;
          end else begin
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_pix     <= r_pix + LP_ONE;
            r_rd_addr <= r_pix + LP_ONE;
            r_rd_en   <= 1'b1;
            r_state   <= ST_RD;
          end
        end
        ST_OUT: begin
          if (bus.win_ready) begin
            r_win_valid <= 1'b0;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_x       <= w_x_nxt;
              r_y       <= w_y_nxt;
              r_pix     <= r_pix + LP_ONE;
              r_rd_addr <= r_pix + LP_ONE;
              r_rd_en   <= 1'b1;
              r_state   <= ST_RD;
            end
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.win_valid = r_win_valid;
  assign bus.win_data  = r_win_data;
`ifdef GWIN_COORD_EN
  assign bus.win_x     = r_win_x;
  assign bus.win_y     = r_win_y;
`endif
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: doc/gaussian_window_gen.md
# gaussian_window_gen

Upstream feeder for the Gaussian stage. Scans the source image in raster order from the pixel DRAM and maintains six line buffers plus a 7x7 shift window. Presents each fully-populated 7x7 neighbourhood as one flat MASKLEN-bit word under a valid/ready handshake, which the Gaussian controller consumes one window per output pixel.

## Interface
- BITS, 8, pixel width
- WIDTH, 7, window edge (fixed 7; 6 line buffers)
- MASKLEN, 392, BITS*WIDTH*WIDTH
- ADDRLEN, 21, DRAM address width
- IMG_W, 64, image width in pixels (≥ WIDTH)
- IMG_H, 64, image height in pixels (≥ WIDTH)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one frame scan; sampled only in IDLE
- rd_en  out  1  DRAM read strobe
- rd_addr  out  ADDRLEN  DRAM read address, y*IMG_W + x
- rd_data  in  BITS  DRAM read data, valid exactly 1 cycle after rd_en
- win_valid  out  1  win_data holds a complete window
- win_ready  in  1  consumer accepts window
- win_data  out  MASKLEN  7x7 window
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after last window accepted

## Operation
- States: IDLE, RD, CAP, OUT, FIN.
- IDLE: on start=1, clear x=y=0, go RD; busy=1.
- RD: rd_en=1, rd_addr=y*IMG_W+x; go CAP.
- CAP: capture rd_data; shift window left one column; new column = six line-buffer entries at column x (oldest row at top) plus rd_data at bottom; write column back into line buffers (rows shift up, rd_data enters as newest).
- After CAP: if y≥6 and x≥6 go OUT, else advance (x,y) and go RD.
- OUT: win_valid=1; hold win_data stable until win_ready=1. On handshake, advance (x,y); go RD, or FIN if last pixel (IMG_W-1, IMG_H-1).
- Advance: x increments; at x=IMG_W-1, x←0 and y increments.
- FIN: done=1 for one cycle, busy=0, go IDLE.
- Window layout: win_data[BITS*(r*WIDTH+c) +: BITS] = pixel(y-6+r, x-6+c), r,c in 0..6; index 0 is the top-left pixel.
- Windows are produced only for fully interior positions: (IMG_W-6)*(IMG_H-6) windows per frame. No border padding.
- Window does not straddle rows. Columns shifted in from a previous row are discarded by the x≥6 gate.
- start while busy: ignored.
- rst at any time, including mid-frame: state IDLE; rd_en, win_valid, busy, done = 0; x=y=0. Line-buffer and window contents are not cleared and need no clearing.

## Timing
- Reset values: rd_en=0, rd_addr=0, win_valid=0, win_data=0, busy=0, done=0.
- All outputs registered.
- Non-output pixel: 2 cycles (RD, CAP).
- Window pixel with win_ready held high: 3 cycles (RD, CAP, OUT). win_valid first rises on cycle 3 of that pixel, counting RD as cycle 1.
- Frame with win_ready=1: 2*IMG_W*IMG_H + (IMG_W-6)*(IMG_H-6) cycles from start-accept to FIN, then done the next cycle.
- Backpressure: while win_valid=1 and win_ready=0, no reads are issued and win_data is frozen.
- Handshake occurs on the cycle both valid and ready are high. win_valid drops the following cycle.

## Configuration
- GWIN_COORD_EN defined: adds ports win_x and win_y, out, ADDRLEN each, giving the centre-pixel coordinates (x-3, y-3). Registered with win_data, reset 0.
- Undefined: ports absent; behaviour otherwise identical.

## Structure
- Shared package gaussian_pkg:
  - BITS, WIDTH, MASKLEN, ADDRLEN constants
  - FSM state typedef
  - helper function for window slice index
- Sub-module gwin_line_buffer: 6 x IMG_W x BITS column-addressed store with one read-modify-write per column. Read column x, write shifted column x in the same CAP cycle.

## Test plan
- IMG_W=IMG_H=8, pixel(addr)=addr, win_ready=1 → exactly 4 windows.
  - First window: word0=0, word6=6, word42=48, word48=54.
  - Last window: word0=9, word48=63.
  - done pulses once; total busy cycles 132.
- Same image, win_ready low 5 cycles on the 2nd window → win_data stable, rd_en=0 throughout; resumes with identical data sequence.
- start pulsed while busy → no restart, window count still 4.
- rst asserted mid-frame (after 1st window) → next cycle all outputs 0. New start yields the full 4-window sequence from the beginning.
- IMG_W=IMG_H=7 → exactly one window equal to the whole image; done 1 cycle after its handshake.
- With GWIN_COORD_EN, 8x8 → (win_x, win_y) sequence (3,3), (4,3), (3,4), (4,4).
